// File: rtl/inst_decode_stage_if.sv
// Fetch-side and decode-side bus of the IF/ID stage.
// The stage itself takes the slave modport.
interface inst_decode_stage_if #(
    parameter int PC_W = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [31:0]     fetch_inst;
    logic [PC_W-1:0] fetch_pc;
    logic            dec_valid;
    logic            dec_ready;
    logic [PC_W-1:0] dec_pc;
    logic [24:0]     Inst;
    logic            ILoad;
    logic            S;
    logic            SB;
    logic            U;
    logic            UJ;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            illegal;
    logic            nop;

    modport master (
        output fetch_valid, fetch_inst, fetch_pc, dec_ready,
        input  fetch_ready, dec_valid, dec_pc, Inst, ILoad, S, SB, U, UJ,
               rs1, rs2, rd, illegal, nop
    );

    modport slave (
        input  fetch_valid, fetch_inst, fetch_pc, dec_ready,
        output fetch_ready, dec_valid, dec_pc, Inst, ILoad, S, SB, U, UJ,
               rs1, rs2, rd, illegal, nop
    );
endinterface

// File: rtl/inst_decode_stage.sv
// IF/ID stage: 2-entry skid FIFO with decode-at-push, so every decode output
// is a register read of the head entry, forced to zero while the FIFO is empty.
module inst_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    inst_decode_stage_if.slave bus
);
    typedef struct packed {
        logic illegal;
        logic uj;
        logic u;
        logic sb;
        logic s;
        logic iload;
    } sel_t;

    // Opcode bits are consumed at push; only the fields after [6:0] are kept.
    typedef struct packed {
        logic [XLEN-1:7] inst;
        logic [PC_W-1:0] pc;
        sel_t            sel;
    } entry_t;

    function automatic sel_t classify(input logic [XLEN-1:0] w);
        sel_t r;
        r = '0;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: r.iload = 1'b1;
            7'b0100011:                         r.s     = 1'b1;
            7'b1100011:                         r.sb    = 1'b1;
            7'b0110111, 7'b0010111:             r.u     = 1'b1;
            7'b1101111:                         r.uj    = 1'b1;
            7'b0110011, 7'b1110011, 7'b0001111: r       = '0;
            default:                            r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    entry_t     entry_q [2];
    entry_t     entry_d [2];
    logic [1:0] count_q, count_d;
    logic       head_q, head_d;
    logic       push, pop, tail;
    entry_t     head_e;

    assign bus.fetch_ready = (count_q != 2'd2);
    assign bus.dec_valid   = (count_q != 2'd0);
    assign push = bus.fetch_valid & bus.fetch_ready & ~flush;
    assign pop  = bus.dec_valid & bus.dec_ready & ~flush;
    // Write slot: the head when empty, the other slot when one entry is held.
    assign tail = head_q ^ (count_q == 2'd1);

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        head_d  = head_q;
        if (flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
        end else begin
            if (push) begin
                entry_d[tail].inst = bus.fetch_inst[XLEN-1:7];
                entry_d[tail].pc   = bus.fetch_pc;
                entry_d[tail].sel  = classify(bus.fetch_inst);
            end
            if (push && !pop)
                count_d = count_q + 2'd1;
            else if (pop && !push)
                count_d = count_q - 2'd1;
            if (pop)
                head_d = ~head_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            head_q     <= 1'b0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
        end
    end

    assign head_e      = bus.dec_valid ? entry_q[head_q] : '0;
    assign bus.dec_pc  = head_e.pc;
    assign bus.Inst    = head_e.inst[31:7];
    assign bus.rs1     = head_e.inst[19:15];
    assign bus.rs2     = head_e.inst[24:20];
    assign bus.rd      = head_e.inst[11:7];
    assign bus.ILoad   = head_e.sel.iload;
    assign bus.S       = head_e.sel.s;
    assign bus.SB      = head_e.sel.sb;
    assign bus.U       = head_e.sel.u;
    assign bus.UJ      = head_e.sel.uj;
    assign bus.illegal = head_e.sel.illegal;
    assign bus.nop     = ~bus.dec_valid | flush;
endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed scenarios plus a randomized run
// against a queue-based model of the FIFO and an opcode-table decoder.
module tb_inst_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    inst_decode_stage_if #(.PC_W(32)) bus ();
    inst_decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;
    ent_t mq[$];

    typedef struct packed {
        logic iload, s, sb, u, uj, ill;
    } exp_t;

    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t e;
        logic [6:0] op;
        e  = '0;
        op = w[6:0];
        if (op inside {7'h03, 7'h13, 7'h67})      e.iload = 1'b1;
        else if (op == 7'h23)                     e.s     = 1'b1;
        else if (op == 7'h63)                     e.sb    = 1'b1;
        else if (op inside {7'h37, 7'h17})        e.u     = 1'b1;
        else if (op == 7'h6f)                     e.uj    = 1'b1;
        else if (!(op inside {7'h33, 7'h73, 7'h0f})) e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t obs_sel();
        exp_t e;
        e = '{bus.ILoad, bus.S, bus.SB, bus.U, bus.UJ, bus.illegal};
        return e;
    endfunction

    // Advance one clock and apply the same transfer to the model.
    task automatic cycle();
        logic push, pop;
        ent_t e;
        push = bus.fetch_valid && (mq.size() < 2) && !flush;
        pop  = (mq.size() > 0) && bus.dec_ready && !flush;
        e.inst = bus.fetch_inst;
        e.pc   = bus.fetch_pc;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] w, input logic [31:0] pc, input logic dr);
        bus.fetch_valid = fv;
        bus.fetch_inst  = w;
        bus.fetch_pc    = pc;
        bus.dec_ready   = dr;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.dec_valid, bus.fetch_ready, bus.nop} !== 3'b011) begin
            errors++;
            $display("FAIL reset_ctrl: got v/r/nop=%b required 011", {bus.dec_valid, bus.fetch_ready, bus.nop});
        end
        checks++;
        if ({bus.Inst, obs_sel(), bus.rs1, bus.rs2, bus.rd, bus.dec_pc} !== '0) begin
            errors++;
            $display("FAIL reset_decode: Inst=%h sel=%b rd=%0d pc=%h required all zero", bus.Inst, obs_sel(), bus.rd, bus.dec_pc);
        end
        rst_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_addi(input string tag);
        drive(1'b1, 32'h00500093, 32'h100, 1'b1);
        cycle();
        bus.fetch_valid = 1'b0;
        checks++;
        if ({bus.dec_valid, bus.ILoad, bus.rd, bus.nop} !== {1'b1, 1'b1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL %s_head: got v=%b ILoad=%b rd=%0d nop=%b required 1 1 1 0", tag, bus.dec_valid, bus.ILoad, bus.rd, bus.nop);
        end
        checks++;
        if (bus.Inst !== 25'h000A001 || bus.dec_pc !== 32'h100 || bus.rs1 !== 5'd0) begin
            errors++;
            $display("FAIL %s_fields: got Inst=%h pc=%h rs1=%0d required 000a001 100 0", tag, bus.Inst, bus.dec_pc, bus.rs1);
        end
        cycle();
        checks++;
        if (bus.dec_valid !== 1'b0 || bus.Inst !== 25'h0) begin
            errors++;
            $display("FAIL %s_drain: got v=%b Inst=%h required 0 0", tag, bus.dec_valid, bus.Inst);
        end
    endtask

    task automatic test_skid();
        drive(1'b1, 32'h00112023, 32'h200, 1'b0);
        cycle();
        bus.fetch_inst = 32'hFE000EE3;
        bus.fetch_pc   = 32'h204;
        cycle();
        bus.fetch_valid = 1'b0;
        checks++;
        if ({bus.fetch_ready, bus.dec_valid, bus.S, bus.rs2, bus.rs1} !== {1'b0, 1'b1, 1'b1, 5'd1, 5'd2} || bus.dec_pc !== 32'h200) begin
            errors++;
            $display("FAIL skid_full: got rdy=%b v=%b S=%b rs2=%0d rs1=%0d pc=%h required 0 1 1 1 2 200",
                     bus.fetch_ready, bus.dec_valid, bus.S, bus.rs2, bus.rs1, bus.dec_pc);
        end
        bus.dec_ready = 1'b1;
        cycle();
        checks++;
        if ({bus.SB, bus.S, bus.fetch_ready} !== 3'b101 || bus.dec_pc !== 32'h204) begin
            errors++;
            $display("FAIL skid_second: got SB=%b S=%b rdy=%b pc=%h required 1 0 1 204", bus.SB, bus.S, bus.fetch_ready, bus.dec_pc);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h123450B7, 32'h300, 1'b1);
        cycle();
        bus.fetch_inst = 32'h0000006F;
        bus.fetch_pc   = 32'h304;
        checks++;
        if (bus.U !== 1'b1 || bus.rd !== 5'd1 || bus.dec_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_lui: got U=%b rd=%0d v=%b required 1 1 1", bus.U, bus.rd, bus.dec_valid);
        end
        cycle();
        bus.fetch_valid = 1'b0;
        checks++;
        if (bus.UJ !== 1'b1 || bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h304) begin
            errors++;
            $display("FAIL b2b_jal: got UJ=%b v=%b pc=%h required 1 1 304", bus.UJ, bus.dec_valid, bus.dec_pc);
        end
        cycle();
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h00500093, 32'h400, 1'b0);
        cycle();
        cycle();
        bus.fetch_inst = 32'h00208033;
        flush = 1'b1;
        #1;
        checks++;
        if ({bus.dec_valid, bus.nop} !== 2'b11) begin
            errors++;
            $display("FAIL flush_cycle: got v=%b nop=%b required 1 1", bus.dec_valid, bus.nop);
        end
        cycle();
        flush = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.dec_ready = 1'b1;
        checks++;
        if ({bus.dec_valid, bus.nop, bus.fetch_ready} !== 3'b011) begin
            errors++;
            $display("FAIL flush_after: got v/nop/rdy=%b required 011", {bus.dec_valid, bus.nop, bus.fetch_ready});
        end
        cycle();
        checks++;
        if (bus.dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got v=%b required 0", bus.dec_valid);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'hFFFFFFFF, 32'h500, 1'b0);
        cycle();
        checks++;
        if (obs_sel() !== exp_t'(6'b000001)) begin
            errors++;
            $display("FAIL illegal_ones: got sel/ill=%b required 000001", obs_sel());
        end
        bus.fetch_inst  = 32'h00208033;
        bus.dec_ready   = 1'b1;
        cycle();
        bus.fetch_valid = 1'b0;
        checks++;
        if (obs_sel() !== '0 || bus.dec_valid !== 1'b1 || bus.rs2 !== 5'd2) begin
            errors++;
            $display("FAIL illegal_rtype: got sel/ill=%b v=%b rs2=%0d required 000000 1 2", obs_sel(), bus.dec_valid, bus.rs2);
        end
        cycle();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h00112023, 32'h600, 1'b0);
        cycle();
        checks++;
        if (bus.dec_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got v=%b required 1", bus.dec_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dec_valid, bus.fetch_ready, bus.nop, bus.S, bus.Inst, bus.dec_pc} !== {3'b011, 1'b0, 25'h0, 32'h0}) begin
            errors++;
            $display("FAIL areset_clear: got v/r/nop=%b S=%b Inst=%h pc=%h required 011 0 0 0",
                     {bus.dec_valid, bus.fetch_ready, bus.nop}, bus.S, bus.Inst, bus.dec_pc);
        end
        mq.delete();
        @(posedge clk);
        #1;
        bus.fetch_valid = 1'b0;
        rst_n = 1'b1;
        test_addi("post_reset");
    endtask

    task automatic test_random();
        logic [6:0] ops [12];
        exp_t e;
        int bad;
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h73, 7'h0f, 7'h00};
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 5) != 0) w[6:0] = ops[$urandom_range(0, 11)];
            drive($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            #1;
            if (mq.size() == 0) e = '0;
            else e = ref_dec(mq[0].inst);
            checks++;
            if ({bus.dec_valid, bus.fetch_ready, bus.nop} !== {mq.size() != 0, mq.size() != 2, (mq.size() == 0) || flush}) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_ctrl[%0d]: got v/r/nop=%b required occupancy %0d flush %b",
                                       i, {bus.dec_valid, bus.fetch_ready, bus.nop}, mq.size(), flush);
            end
            checks++;
            if (obs_sel() !== e) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_sel[%0d]: got %b required %b", i, obs_sel(), e);
            end
            checks++;
            if (mq.size() == 0) begin
                if ({bus.Inst, bus.dec_pc, bus.rs1, bus.rs2, bus.rd} !== '0) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL rand_empty[%0d]: got Inst=%h pc=%h required 0", i, bus.Inst, bus.dec_pc);
                end
            end else if (bus.Inst !== mq[0].inst[31:7] || bus.dec_pc !== mq[0].pc ||
                         bus.rs1 !== mq[0].inst[19:15] || bus.rs2 !== mq[0].inst[24:20] || bus.rd !== mq[0].inst[11:7]) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_head[%0d]: got Inst=%h pc=%h required word %h pc %h",
                                       i, bus.Inst, bus.dec_pc, mq[0].inst, mq[0].pc);
            end
            cycle();
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        cycle();
        cycle();
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_addi("addi");
        test_skid();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
